canny_nms: RTL and testbench
============================

Name: canny_nms

Overview:
- Streaming Canny edge stage for the SIFT front end.
- Walks a W×H image buffer in raster order by driving a read address, and accepts one gradient magnitude plus orientation bin per clock.
- Performs 3×3 non-maximum suppression along the gradient direction, gated by a magnitude threshold, and emits one edge bit per pixel.

Parameters:
- W, 512, image width in pixels (≥4)
- H, 512, image height in pixels (≥3)
- ADDR_W, 18, address width; W*H ≤ 2^ADDR_W

Ports:
- clk1  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- mag1  in  8  gradient magnitude of pixel at current addr (unsigned)
- mag2  in  8  edge threshold (unsigned, quasi-static)
- dir1  in  6  gradient orientation bin, 0..35, 10° per bin
- addr  out  ADDR_W  raster address of the pixel whose mag1/dir1 is sampled at the next rising edge
- canny_edge  out  1  registered edge decision, 1 = edge pixel

Behaviour:
- Reset (rst=0, asynchronous): addr=0, canny_edge=0, line buffers and window registers cleared to 0.
- addr: free-running from 0, +1 per clk1 cycle; wraps from W*H-1 to 0 with no gap. No stall or valid handshake; one pixel per cycle.
- Sampling: mag1/dir1 at a rising edge belong to pixel p = addr value before that edge.
- Window: two line buffers of W×8-bit magnitude plus a delayed center-row orientation (6 bits) form a 3×3 magnitude window with center c = pixel p-W-1.
- Direction quantisation: a = (dir1 mod 18)×10°.
  - a ∈ {0,10,20,160,170}: compare left (x-1,y) and right (x+1,y).
  - a ∈ {30..60}: compare (x+1,y-1) and (x-1,y+1).
  - a ∈ {70..110}: compare up (x,y-1) and down (x,y+1).
  - a ∈ {120..150}: compare (x-1,y-1) and (x+1,y+1).
  - dir1 ≥ 36: treated as horizontal.
- Edge rule: edge = (c > mag2) AND (c ≥ n1) AND (c ≥ n2). Threshold is strict; ties with neighbours pass.
- Borders: pixels in row 0, row H-1, column 0 or column W-1 output 0. Windows straddling a row end or a frame wrap therefore never produce an edge.
- Latency: the decision for pixel p is visible on canny_edge while addr == (p+W+3) mod (W*H).
  - After reset, the first W+3 cycles output 0.
- Reset mid-frame: immediate return to the reset state; scanning restarts at addr 0. No partial-frame recovery.
- Arithmetic: all comparisons unsigned 8-bit; no overflow paths.

Decomposition:
- Shared package: W, H, ADDR_W defaults; a 2-bit direction-class enum (DIR_H, DIR_45, DIR_V, DIR_135); a bin→class lookup function.
- One sub-module, canny_line_buffer: a W-deep shift/RAM delay line of configurable data width. Instantiate twice for magnitude and once for the center-row orientation.
- Column/row counters and NMS compare logic live in the top.

Test Plan (W=8, H=8 unless noted):
1. Reset: hold rst=0 for 10 cycles with random inputs → addr=0 and canny_edge=0 throughout. Release → addr reads 1,2,3… on successive cycles, and 0 again after 64 cycles.
2. Flat field: mag1=50, mag2=10, dir1=0 → canny_edge=1 exactly for interior pixels (rows/cols 1..6), i.e. 36 ones per frame. 0 during the first W+3=11 cycles after reset.
3. Vertical ridge: mag1=100 at column 3, 20 elsewhere, mag2=50, dir1=0 → edge only for pixels (3,y), y=1..6. Pixel (3,1) appears while addr=(11+11)=22.
4. Same ridge with dir1=9 (90°, vertical compare) → column 3 interior still 1 (ties), all others 0 (20 ≤ 50).
5. Threshold boundary: mag1=40 everywhere, mag2=40 → all 0. Change to mag2=39 → interior all 1.
6. Ramp plus mid-frame reset: mag1=column×10, dir1=0, mag2=0 → all 0 (right neighbour larger). Assert rst low at addr=30 → canny_edge=0 and addr=0 the same cycle; restart is clean.

Source files
------------

// File: rtl/canny_nms_pkg.sv
// Shared defaults, direction classes and the orientation-bin classifier for canny_nms.
// Pure declarations; no logic and no latency.
// No flow control lives here.
package canny_nms_pkg;

  localparam int CANNY_W      = 512;
  localparam int CANNY_H      = 512;
  localparam int CANNY_ADDR_W = 18;

  // Which neighbour pair the non-maximum suppression compares against
  typedef enum logic [1:0] {
    DIR_H   = 2'd0,  // left / right
    DIR_45  = 2'd1,  // upper-right / lower-left
    DIR_V   = 2'd2,  // up / down
    DIR_135 = 2'd3   // upper-left / lower-right
  } dir_class_t;

  // Fold a 10-degree orientation bin onto 0..170 degrees and pick its compare axis.
  // Out-of-range bins (>= 36) fall back to the horizontal compare.
  function automatic dir_class_t bin_to_class(input logic [5:0] i_bin);
    logic [5:0] w_fold;
    w_fold = (i_bin >= 6'd18) ? (i_bin - 6'd18) : i_bin;
    if (i_bin >= 6'd36) begin
      return DIR_H;
    end else if (w_fold <= 6'd2 || w_fold >= 6'd16) begin
      return DIR_H;
    end else if (w_fold <= 6'd6) begin
      return DIR_45;
    end else if (w_fold <= 6'd11) begin
      return DIR_V;
    end else begin
      return DIR_135;
    end
  endfunction

endpackage

// File: rtl/canny_line_buffer.sv
// One image row of delay: o_dat is the sample pushed DEPTH clocks earlier.
// Latency DEPTH cycles, shifts every clock.
// No backpressure; the stream advances unconditionally one pixel per cycle.
module canny_line_buffer
  import canny_nms_pkg::*;
#(
  parameter int DEPTH = CANNY_W,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_dat,
  output logic [DW-1:0] o_dat
);

  logic [DW-1:0] r_mem [DEPTH];

  // Shift the row one position per pixel; reset clears the whole row
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_mem[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_dat = r_mem[DEPTH-1];

endmodule

// File: rtl/canny_nms.sv
// Raster-scans the image buffer and applies 3x3 non-maximum suppression with a threshold.
// Decision for pixel p shows on canny_edge while addr == p+W+3 (mod W*H).
// No backpressure: one pixel consumed and one decision produced every clock.
module canny_nms
  import canny_nms_pkg::*;
#(
  parameter int W      = CANNY_W,
  parameter int H      = CANNY_H,
  parameter int ADDR_W = CANNY_ADDR_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        mag1,
  input  logic [7:0]        mag2,
  input  logic [5:0]        dir1,
  output logic [ADDR_W-1:0] addr,
  output logic              canny_edge
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);

  logic [ADDR_W-1:0] r_addr;
  logic [XW-1:0]     r_cx;
  logic [YW-1:0]     r_cy;
  logic [7:0]        r_win [3][3];  // [row: up, centre, down][col: left, centre, right]
  logic [5:0]        r_dir_n;
  logic [5:0]        r_dir_c;
  logic              r_edge;

  logic [7:0]        w_mag_up1;
  logic [7:0]        w_mag_up2;
  logic [5:0]        w_dir_up1;
  logic [7:0]        w_c;
  logic [7:0]        w_n1;
  logic [7:0]        w_n2;
  dir_class_t        w_class;
  logic              w_border;
  logic              w_edge;

  // Read address walks the frame and wraps with no idle cycle
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (r_addr == LAST_ADDR) begin
      r_addr <= '0;
    end else begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Position of the current window centre, which trails addr by W+2 pixels
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_cx <= XW'(W - 2);
      r_cy <= YW'(H - 2);
    end else if (r_cx == XW'(W - 1)) begin
      r_cx <= '0;
      r_cy <= (r_cy == YW'(H - 1)) ? '0 : r_cy + YW'(1);
    end else begin
      r_cx <= r_cx + XW'(1);
    end
  end

  canny_line_buffer #(.DEPTH(W), .DW(8)) u_lb_mag0 (
    .i_clk   (clk1),
    .i_rst_n (rst),
    .i_dat   (mag1),
    .o_dat   (w_mag_up1)
  );

  canny_line_buffer #(.DEPTH(W), .DW(8)) u_lb_mag1 (
    .i_clk   (clk1),
    .i_rst_n (rst),
    .i_dat   (w_mag_up1),
    .o_dat   (w_mag_up2)
  );

  canny_line_buffer #(.DEPTH(W), .DW(6)) u_lb_dir (
    .i_clk   (clk1),
    .i_rst_n (rst),
    .i_dat   (dir1),
    .o_dat   (w_dir_up1)
  );

  // Slide the 3x3 magnitude window right by one column; the newest column enters on the right
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_mag_up2;
      r_win[1][2] <= w_mag_up1;
      r_win[2][2] <= mag1;
    end
  end

  // Orientation of the centre pixel: one row from the line buffer plus one column of delay
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_dir_n <= '0;
      r_dir_c <= '0;
    end else begin
      r_dir_n <= w_dir_up1;
      r_dir_c <= r_dir_n;
    end
  end

  assign w_class  = bin_to_class(r_dir_c);
  assign w_c      = r_win[1][1];
  assign w_border = (r_cx == '0) || (r_cx == XW'(W - 1)) ||
                    (r_cy == '0) || (r_cy == YW'(H - 1));

  // Pick the two neighbours lying along the gradient direction
  always_comb begin
    w_n1 = r_win[1][0];
    w_n2 = r_win[1][2];
    case (w_class)
      DIR_45: begin
        w_n1 = r_win[0][2];
        w_n2 = r_win[2][0];
      end
      DIR_V: begin
        w_n1 = r_win[0][1];
        w_n2 = r_win[2][1];
      end
      DIR_135: begin
        w_n1 = r_win[0][0];
        w_n2 = r_win[2][2];
      end
      default: begin
        w_n1 = r_win[1][0];
        w_n2 = r_win[1][2];
      end
    endcase
  end

  // Strict threshold, ties with neighbours still count as a local maximum
  assign w_edge = !w_border && (w_c > mag2) && (w_c >= w_n1) && (w_c >= w_n2);

  // Register the decision so it lands one cycle after the window settles
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_edge <= 1'b0;
    end else begin
      r_edge <= w_edge;
    end
  end

  assign addr       = r_addr;
  assign canny_edge = r_edge;

endmodule

// File: tb/tb_canny_nms.sv
module tb_canny_nms;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int AW = 6;
  localparam int LAT = W + 3;

  logic          clk1 = 1'b0;
  logic          rst  = 1'b0;
  logic [7:0]    mag1 = '0;
  logic [7:0]    mag2 = '0;
  logic [5:0]    dir1 = '0;
  logic [AW-1:0] addr;
  logic          canny_edge;

  int img_mag [N];
  int img_dir [N];
  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  always #5 clk1 = ~clk1;

  canny_nms #(.W(W), .H(H), .ADDR_W(AW)) dut (
    .clk1       (clk1),
    .rst        (rst),
    .mag1       (mag1),
    .mag2       (mag2),
    .dir1       (dir1),
    .addr       (addr),
    .canny_edge (canny_edge)
  );

  // Reference: the edge decision for pixel p of the stored image, from geometry and angles
  function automatic logic model_edge(input int p);
    int x, y, ang, dx, dy, c, n1, n2;
    x = p % W;
    y = p / W;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 1'b0;
    ang = (img_dir[p] >= 36) ? 0 : (img_dir[p] % 18) * 10;
    if (ang <= 20 || ang >= 160) begin dx = 1; dy = 0;  end
    else if (ang <= 60)          begin dx = 1; dy = -1; end
    else if (ang <= 110)         begin dx = 0; dy = 1;  end
    else                         begin dx = 1; dy = 1;  end
    c  = img_mag[p];
    n1 = img_mag[(y + dy) * W + (x + dx)];
    n2 = img_mag[(y - dy) * W + (x - dx)];
    return (c > int'(mag2)) && (c >= n1) && (c >= n2);
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Hold reset for some cycles with random pixel inputs, then release on a falling edge
  task automatic apply_reset(input int cycles);
    @(negedge clk1);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      mag1 = 8'($urandom);
      dir1 = 6'($urandom);
      #1;
      chk("rst_addr", i, 32'(addr), 32'd0);
      chk("rst_edge", i, 32'(canny_edge), 32'd0);
      @(negedge clk1);
    end
    rst  = 1'b1;
    ncyc = 0;
  endtask

  // Feed the stored image at the DUT's address and check address and edge every cycle
  task automatic run(input string tag, input int cycles);
    logic exp;
    for (int i = 0; i < cycles; i++) begin
      chk("addr", ncyc, 32'(addr), 32'(ncyc % N));
      exp = (ncyc < LAT) ? 1'b0 : model_edge((ncyc - LAT) % N);
      chk(tag, ncyc, 32'(canny_edge), 32'(exp));
      mag1 = 8'(img_mag[addr]);
      dir1 = 6'(img_dir[addr]);
      @(negedge clk1);
      ncyc++;
    end
  endtask

  task automatic fill(input int m, input int d);
    for (int p = 0; p < N; p++) begin
      img_mag[p] = m;
      img_dir[p] = d;
    end
  endtask

  initial begin
    // Reset behaviour followed by a flat field; two frames exercise the address wrap
    fill(50, 0);
    mag2 = 8'd10;
    apply_reset(10);
    run("flat", 2 * N + 5);

    // Vertical ridge at column 3 compared horizontally
    for (int p = 0; p < N; p++) begin
      img_mag[p] = (p % W == 3) ? 100 : 20;
      img_dir[p] = 0;
    end
    mag2 = 8'd50;
    apply_reset(3);
    run("ridge_h", 2 * N);

    // Same ridge compared vertically: ties along the column still pass
    for (int p = 0; p < N; p++) img_dir[p] = 9;
    apply_reset(3);
    run("ridge_v", 2 * N);

    // Threshold is strict: equal to threshold fails, one above passes
    fill(40, 0);
    mag2 = 8'd40;
    apply_reset(3);
    run("thr_eq", N + LAT);
    mag2 = 8'd39;
    apply_reset(3);
    run("thr_gt", N + LAT);

    // Ramp never peaks horizontally; reset asserted mid-frame takes effect at once
    for (int p = 0; p < N; p++) begin
      img_mag[p] = (p % W) * 10;
      img_dir[p] = 0;
    end
    mag2 = 8'd0;
    apply_reset(3);
    run("ramp", 30);
    chk("mid_addr_pre", ncyc, 32'(addr), 32'd30);
    rst = 1'b0;
    #1;
    chk("mid_addr", ncyc, 32'(addr), 32'd0);
    chk("mid_edge", ncyc, 32'(canny_edge), 32'd0);
    apply_reset(2);
    run("ramp_restart", N + LAT);

    // Random images covering all direction classes, out-of-range bins and ties
    for (int t = 0; t < 4; t++) begin
      for (int p = 0; p < N; p++) begin
        img_mag[p] = int'($urandom_range(0, 15));
        img_dir[p] = int'($urandom_range(0, 63));
      end
      mag2 = 8'($urandom_range(0, 8));
      apply_reset(2);
      run("rand", N + LAT + 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
